// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobe, per-tick debounce of press and
// release, and a one-entry output buffer with a sticky overrun flag.
module keypad_scanner #(
  parameter int SCAN_BITS = 18,
  parameter int DEB_SCANS = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overrun
);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, RELEASE} state_t;

  // Counters reach DEB_SCANS on the tick that compares against DEB_LAST.
  localparam logic [3:0] DEB_LAST = 4'(DEB_SCANS - 1);

  logic [3:0]           row_meta, rsync;
  logic [SCAN_BITS-1:0] presc;
  logic                 tick;

  state_t     state, state_nxt;
  logic [1:0] col_idx, col_idx_nxt;
  logic [1:0] row_idx, row_idx_nxt;
  logic [3:0] deb_cnt, deb_cnt_nxt;
  logic [3:0] rel_cnt, rel_cnt_nxt;

  logic       any_low;
  logic [1:0] low_idx;
  logic       row_match;
  logic       offer;
  logic [3:0] offer_code;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hf;
      rsync    <= 4'hf;
    end else begin
      row_meta <= row;
      rsync    <= row_meta;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= presc + SCAN_BITS'(1);
  end

  assign tick = &presc;

  // Lowest-index low row wins when several rows are pulled down.
  always_comb begin
    any_low = (rsync != 4'hf);
    if      (!rsync[0]) low_idx = 2'd0;
    else if (!rsync[1]) low_idx = 2'd1;
    else if (!rsync[2]) low_idx = 2'd2;
    else                low_idx = 2'd3;
    row_match = any_low && (low_idx == row_idx);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= SCAN;
      col_idx <= 2'd0;
      row_idx <= 2'd0;
      deb_cnt <= 4'd0;
      rel_cnt <= 4'd0;
    end else begin
      state   <= state_nxt;
      col_idx <= col_idx_nxt;
      row_idx <= row_idx_nxt;
      deb_cnt <= deb_cnt_nxt;
      rel_cnt <= rel_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    col_idx_nxt = col_idx;
    row_idx_nxt = row_idx;
    deb_cnt_nxt = deb_cnt;
    rel_cnt_nxt = rel_cnt;
    if (tick) begin
      case (state)
        SCAN: begin
          if (any_low) begin
            row_idx_nxt = low_idx;
            deb_cnt_nxt = 4'd1;
            state_nxt   = DEBOUNCE;
          end else begin
            col_idx_nxt = col_idx + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (row_match) begin
            if (deb_cnt == DEB_LAST) begin
              deb_cnt_nxt = 4'd0;
              state_nxt   = RELEASE;
            end else begin
              deb_cnt_nxt = deb_cnt + 4'd1;
            end
          end else begin
            deb_cnt_nxt = 4'd0;
            col_idx_nxt = col_idx + 2'd1;
            state_nxt   = SCAN;
          end
        end
        RELEASE: begin
          if (any_low) begin
            rel_cnt_nxt = 4'd0;
          end else if (rel_cnt == DEB_LAST) begin
            rel_cnt_nxt = 4'd0;
            col_idx_nxt = col_idx + 2'd1;
            state_nxt   = SCAN;
          end else begin
            rel_cnt_nxt = rel_cnt + 4'd1;
          end
        end
        default: state_nxt = SCAN;
      endcase
    end
  end

  always_comb begin
    col        = ~(4'b0001 << col_idx);
    offer      = tick && (state == DEBOUNCE) && row_match && (deb_cnt == DEB_LAST);
    offer_code = {row_idx, col_idx};
  end

  // A same-cycle consume frees the slot for the newly offered key.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (offer) begin
      if (!key_valid || key_ready) begin
        key_code  <= offer_code;
        key_valid <= 1'b1;
      end else begin
        overrun   <= 1'b1;
      end
    end else if (key_valid && key_ready) begin
      key_valid <= 1'b0;
    end
  end

endmodule
